// File: rtl/tdm_demux.sv
// tdm_demux -- serial TDM frame demultiplexer.
//
// Collects CHANNELS consecutive valid bits (slot 0 first, marked by
// frameStart) into a parallel word. Slot k lands in out[k]. A completed
// frame loads out and pulses outValid; a frameStart arriving mid-frame
// aborts the partial frame with a frameError pulse and restarts at slot 0
// using that same bit.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to append one even-parity
// bit per frame (CHECK state). A parity match loads out; a mismatch pulses
// frameError and leaves out untouched.
//
// Ports:
//   clk        : clock, rising edge
//   resetN     : asynchronous active-low reset
//   in         : serial data bit
//   inValid    : in is valid this cycle (low = stall)
//   frameStart : current valid bit is slot 0 of a new frame
//   out        : registered channel bits of the last accepted frame
//   outValid   : one-cycle pulse when out updates
//   frameError : one-cycle pulse on abort / parity failure
module tdm_demux #(
  parameter int CHANNELS = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                in,
  input  logic                inValid,
  input  logic                frameStart,
  output logic [CHANNELS-1:0] out,
  output logic                outValid,
  output logic                frameError
);

  localparam int            CW   = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [1:0] CHECK   = 2'd2;
`endif

  logic [1:0]          state;
  logic [CW-1:0]       slotCnt;
  logic [CHANNELS-1:0] asmReg;
  logic [CHANNELS-1:0] asmNext;  // assembly word with the current bit merged in
  logic [CHANNELS-1:0] slot0;    // fresh frame holding only the current bit

  always_comb begin
    asmNext          = asmReg;
    asmNext[slotCnt] = in;
    slot0            = '0;
    slot0[0]         = in;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      slotCnt    <= '0;
      asmReg     <= '0;
      out        <= '0;
      outValid   <= 1'b0;
      frameError <= 1'b0;
    end else begin
      outValid   <= 1'b0;
      frameError <= 1'b0;
      if (inValid) begin
        case (state)
          IDLE: begin
            // Bits without frameStart are dropped until a frame begins.
            if (frameStart) begin
              asmReg  <= slot0;
              slotCnt <= ONE;
              state   <= COLLECT;
            end
          end
          COLLECT: begin
            if (frameStart) begin
              // Abort: the marker bit itself becomes slot 0 of the new frame.
              frameError <= 1'b1;
              asmReg     <= slot0;
              slotCnt    <= ONE;
            end else begin
              asmReg <= asmNext;
              if (slotCnt == LAST) begin
                slotCnt <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                state   <= CHECK;
`else
                // Load from asmNext so the last bit is included this edge.
                out      <= asmNext;
                outValid <= 1'b1;
                state    <= IDLE;
`endif
              end else begin
                slotCnt <= slotCnt + ONE;
              end
            end
          end
`ifdef TDM_DEMUX_PARITY_EN
          CHECK: begin
            if (frameStart) begin
              frameError <= 1'b1;
              asmReg     <= slot0;
              slotCnt    <= ONE;
              state      <= COLLECT;
            end else begin
              // Even parity: parity bit equals XOR of the data bits.
              if (in == ^asmReg) begin
                out      <= asmReg;
                outValid <= 1'b1;
              end else begin
                frameError <= 1'b1;
              end
              state <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int CH = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL = CH + 1;
`else
  localparam int FL = CH;
`endif

  logic          clk = 1'b0;
  logic          resetN;
  logic          in;
  logic          inValid;
  logic          frameStart;
  logic [CH-1:0] out;
  logic          outValid;
  logic          frameError;

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int lastPulse = 0;
  int vldCnt = 0;
  int errCnt = 0;

  tdm_demux #(.CHANNELS(CH)) dut (
    .clk(clk), .resetN(resetN), .in(in), .inValid(inValid),
    .frameStart(frameStart), .out(out), .outValid(outValid),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (outValid)   vldCnt++;
    if (frameError) errCnt++;
  end

  // One cycle: drive at negedge, observe results 1ns after the rising edge.
  task automatic step(input logic v, input logic fs, input logic b);
    @(negedge clk);
    inValid = v; frameStart = fs; in = b;
    @(posedge clk); #1;
    cyc++;
    if (outValid) lastPulse = cyc;
  endtask

  task automatic sendBits(input logic [CH-1:0] d);
    for (int i = 0; i < CH; i++) step(1'b1, i == 0, d[i]);
  endtask

  task automatic sendFrame(input logic [CH-1:0] d);
    sendBits(d);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic test_reset;
    resetN = 1'b0; in = 1'b0; inValid = 1'b0; frameStart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk++; if (out !== 8'h00) begin err++; $display("FAIL reset_out: got %h expected 00", out); end
    chk++; if (outValid !== 1'b0) begin err++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
    chk++; if (frameError !== 1'b0) begin err++; $display("FAIL reset_frameError: got %b expected 0", frameError); end
    @(negedge clk); resetN = 1'b1;
  endtask

  task automatic test_basic;
    logic [CH-1:0] d;
    int v0;
    d = 8'h4D;  // bits 1,0,1,1,0,0,1,0 from slot 0
    v0 = vldCnt;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CH; i++) begin
      step(1'b1, i == 0, d[i]);
      if (i == CH - 2) begin
        chk++; if (outValid !== 1'b0) begin err++; $display("FAIL basic_early: got outValid=%b expected 0", outValid); end
      end
    end
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    chk++; if (outValid !== 1'b1) begin err++; $display("FAIL basic_pulse: got %b expected 1", outValid); end
    chk++; if (out !== 8'h4D) begin err++; $display("FAIL basic_out: got %h expected 4d", out); end
    step(1'b0, 1'b0, 1'b0);
    chk++; if (out !== 8'h4D) begin err++; $display("FAIL basic_hold: got %h expected 4d", out); end
    chk++; if (vldCnt - v0 != 1) begin err++; $display("FAIL basic_single: got %0d pulses expected 1", vldCnt - v0); end
  endtask

  task automatic test_stall;
    logic [CH-1:0] d;
    int start;
    logic bad;
    d = 8'h4D; start = cyc; bad = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, d[i]);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b1);  // frameStart ignored while invalid
      if (outValid !== 1'b0 || frameError !== 1'b0) bad = 1'b1;
    end
    chk++; if (bad) begin err++; $display("FAIL stall_quiet: got a pulse during stall expected none"); end
    for (int i = 4; i < CH; i++) step(1'b1, 1'b0, d[i]);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    chk++; if (outValid !== 1'b1) begin err++; $display("FAIL stall_pulse: got %b expected 1", outValid); end
    chk++; if (out !== 8'h4D) begin err++; $display("FAIL stall_out: got %h expected 4d", out); end
    chk++; if (lastPulse - start != FL + 3) begin err++; $display("FAIL stall_latency: got %0d expected %0d", lastPulse - start, FL + 3); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b0);
    step(1'b1, 1'b1, 1'b1);  // abort at slot 5; this bit is new slot 0
    chk++; if (frameError !== 1'b1) begin err++; $display("FAIL abort_err: got %b expected 1", frameError); end
    chk++; if (outValid !== 1'b0) begin err++; $display("FAIL abort_noValid: got %b expected 0", outValid); end
    chk++; if (out !== 8'h4D) begin err++; $display("FAIL abort_outHeld: got %h expected 4d", out); end
    for (int i = 1; i < CH; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i < CH - 1 && out !== 8'h4D) bad = 1'b1;
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (out !== 8'h4D) bad = 1'b1;
    step(1'b1, 1'b0, 1'b0);
`endif
    chk++; if (bad) begin err++; $display("FAIL abort_holdDuring: out changed early expected 4d"); end
    chk++; if (out !== 8'hFF || outValid !== 1'b1) begin err++; $display("FAIL abort_newFrame: got out=%h vld=%b expected ff/1", out, outValid); end
    step(1'b0, 1'b0, 1'b0);
    chk++; if (frameError !== 1'b0) begin err++; $display("FAIL abort_errOnce: got %b expected 0", frameError); end
  endtask

  task automatic test_back_to_back;
    int p1, e0;
    e0 = errCnt;
    sendFrame(8'hA5);
    chk++; if (out !== 8'hA5 || outValid !== 1'b1) begin err++; $display("FAIL b2b_first: got out=%h vld=%b expected a5/1", out, outValid); end
    p1 = lastPulse;
    sendFrame(8'h3C);
    chk++; if (out !== 8'h3C || outValid !== 1'b1) begin err++; $display("FAIL b2b_second: got out=%h vld=%b expected 3c/1", out, outValid); end
    chk++; if (lastPulse - p1 != FL) begin err++; $display("FAIL b2b_spacing: got %0d expected %0d", lastPulse - p1, FL); end
    step(1'b0, 1'b0, 1'b0);
    chk++; if (errCnt != e0) begin err++; $display("FAIL b2b_noErr: got %0d errors expected 0", errCnt - e0); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    v0 = vldCnt; e0 = errCnt;
    @(negedge clk); inValid = 1'b0; frameStart = 1'b0; resetN = 1'b0;
    #1;
    chk++; if (out !== 8'h00) begin err++; $display("FAIL rstmid_out: got %h expected 00", out); end
    @(negedge clk); resetN = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk++; if (vldCnt != v0 || errCnt != e0) begin err++; $display("FAIL rstmid_noPulse: got vld=%0d err=%0d expected 0/0", vldCnt - v0, errCnt - e0); end
    sendFrame(8'h01);
    chk++; if (out !== 8'h01 || outValid !== 1'b1) begin err++; $display("FAIL rstmid_next: got out=%h vld=%b expected 01/1", out, outValid); end
  endtask

  task automatic test_idle_discard;
    int v0, e0;
    step(1'b0, 1'b0, 1'b0);
    v0 = vldCnt; e0 = errCnt;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk++; if (vldCnt != v0 || errCnt != e0 || out !== 8'h01) begin err++; $display("FAIL idle_discard: got vld=%0d err=%0d out=%h expected 0/0/01", vldCnt - v0, errCnt - e0, out); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity;
    sendBits(8'h4D);
    step(1'b1, 1'b0, 1'b0);
    chk++; if (out !== 8'h4D || outValid !== 1'b1) begin err++; $display("FAIL parity_good: got out=%h vld=%b expected 4d/1", out, outValid); end
    sendBits(8'hFE);
    step(1'b1, 1'b0, 1'b0);  // FE has 7 ones: parity 0 is wrong
    chk++; if (frameError !== 1'b1 || outValid !== 1'b0) begin err++; $display("FAIL parity_bad: got err=%b vld=%b expected 1/0", frameError, outValid); end
    chk++; if (out !== 8'h4D) begin err++; $display("FAIL parity_outHeld: got %h expected 4d", out); end
    sendBits(8'h4D);
    step(1'b1, 1'b0, 1'b1);
    chk++; if (frameError !== 1'b1 || out !== 8'h4D) begin err++; $display("FAIL parity_bad4d: got err=%b out=%h expected 1/4d", frameError, out); end
    step(1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_idle_discard;
`ifdef TDM_DEMUX_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", chk, err);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001: The block SHALL have parameter CHANNELS, default 8, meaning number of time slots per frame; legal range 2..16.
REQ-002: The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-003: The block SHALL have port resetN, input, 1 bit, meaning asynchronous active-low reset.
REQ-004: The block SHALL have port in, input, 1 bit, meaning the serial time-multiplexed data bit.
REQ-005: The block SHALL have port inValid, input, 1 bit, meaning in is valid this cycle; a slot is consumed only when high.
REQ-006: The block SHALL have port frameStart, input, 1 bit, meaning the current valid bit is slot 0 of a new frame.
REQ-007: The block SHALL have port out, output, CHANNELS bits, meaning the registered demultiplexed channel bits of the last accepted frame.
REQ-008: The block SHALL have port outValid, output, 1 bit, meaning a one-cycle pulse marking an out update.
REQ-009: The block SHALL have port frameError, output, 1 bit, meaning a one-cycle pulse on a frame abort or check failure.

Function
REQ-010: The block SHALL implement states IDLE and COLLECT, plus CHECK when the configuration macro is defined.
REQ-011: In IDLE, when inValid=1 and frameStart=1, the block SHALL store in as slot 0, set the slot counter to 1, and enter COLLECT.
REQ-012: In IDLE, bits with frameStart=0 SHALL be discarded with no output change.
REQ-013: In COLLECT, each inValid=1 cycle with frameStart=0 SHALL store in at the slot-counter index and increment the counter.
REQ-014: Slot k SHALL map to out[k], with slot 0 in the LSB.
REQ-015: inValid=0 SHALL stall the block: no slot consumed, counter held, no timeout.
REQ-016: frameStart is significant only when inValid=1.
REQ-017: When slot CHANNELS-1 is stored (macro undefined), the block SHALL load out from the assembled bits and pulse outValid on that same edge, then return to IDLE. The result is visible in the cycle after the last bit is sampled.
REQ-018: A frameStart=1 with inValid=1 in COLLECT SHALL pulse frameError, discard the partial frame, leave out unchanged, and restart at slot 0 with that bit, staying in COLLECT.
REQ-019: Frames SHALL be accepted back-to-back: a frameStart in the cycle immediately after completion SHALL be accepted with no bubble.
REQ-020: out SHALL hold its value between updates.
REQ-021: outValid and frameError SHALL never both assert in the same cycle.

Reset
REQ-022: While resetN=0, the block SHALL asynchronously set state=IDLE, slot counter=0, assembly register=0, out=0, outValid=0, and frameError=0.
REQ-023: Reset asserted mid-frame SHALL drop the partial frame without an error pulse.
REQ-024: After reset release, the block SHALL start acting on the first rising edge.

Configuration
REQ-025: The macro TDM_DEMUX_PARITY_EN SHALL control a parity check.
- When defined: after slot CHANNELS-1, the block SHALL enter CHECK and consume one additional valid bit as even parity over the CHANNELS data bits.
- In CHECK, a match SHALL load out and pulse outValid; a mismatch SHALL pulse frameError and leave out unchanged; either outcome returns to IDLE.
- In CHECK, frameStart=1 SHALL be handled as an abort per REQ-018.
- When undefined: there is no CHECK state, frames are CHANNELS bits long, and REQ-017 applies.

Verification
REQ-026: Reset, then one frame at CHANNELS=8 with bits 1,0,1,1,0,0,1,0 on consecutive valid cycles -> out=8'h4D and a single outValid pulse one cycle after the last bit.
REQ-027: The same frame with inValid=0 for 3 cycles after slot 3 -> identical out=8'h4D, with the outValid pulse delayed by 3 cycles.
REQ-028: frameStart re-asserted at slot 5 followed by a full frame of all ones -> frameError pulse at the abort, then out=8'hFF; out keeps its old value until then.
REQ-029: Two frames back-to-back, 8'hA5 then 8'h3C, with no gap -> two outValid pulses exactly 8 cycles apart; out=8'hA5 then 8'h3C.
REQ-030: resetN pulsed low at slot 4 -> out=0 and no pulses; a following frame 8'h01 -> out=8'h01.
REQ-031 (TDM_DEMUX_PARITY_EN): frame 8'h4D with parity bit 0 -> out=8'h4D and outValid; the same frame with parity bit 1 -> frameError and out unchanged.
